rf_writeback_arbiter: RTL and testbench
=======================================

# rf_writeback_arbiter

Write-side master for the 32x32 general-purpose register file: merges results from the single-cycle ALU path and the multi-cycle multiply/divide unit (MDU) onto the register file's single write port. It drives the write enable, address and data, buffers MDU results in a small FIFO, and keeps a pending-destination scoreboard that decode uses to stall on RAW hazards. It sits between execute/MDU and the register file's write port.

## Interface
- FIFO_DEPTH, 4, MDU result buffer entries; power of two, >= 2
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- alu_valid_i  in  1  ALU result present
- alu_rd_i  in  5  ALU destination register
- alu_data_i  in  32  ALU result
- alu_ready_o  out  1  ALU result accepted this cycle
- mdu_valid_i  in  1  MDU result present
- mdu_rd_i  in  5  MDU destination register
- mdu_data_i  in  32  MDU result
- mdu_ready_o  out  1  MDU result accepted this cycle
- issue_valid_i  in  1  decode issues an instruction that writes rd
- issue_rd_i  in  5  destination of issued instruction
- we_o  out  1  register file write enable
- waddr_o  out  5  register file write address
- wdata_o  out  32  register file write data
- busy_o  out  32  scoreboard; bit r set = write to xr pending
- illegal_issue_o  out  1  sticky: issue to an already-busy register

## Operation
- Handshake: transfer when valid & ready. Sources hold valid/rd/data stable until accepted.
- mdu_ready_o = ~fifo_full. MDU results always go through the FIFO; no bypass. rd = x0: accepted, not stored.
- alu_ready_o = ~fifo_full. ALU rd = x0: accepted, no write.
- Arbitration at each posedge, fixed priority:
  - FIFO full: pop head to write port (ALU blocked).
  - else alu_valid_i: ALU to write port.
  - else FIFO non-empty: pop head.
  - else no write.
- Simultaneous MDU push and pop: count unchanged; push while full impossible (ready low).
- Scoreboard: issue_valid_i with issue_rd_i != 0 sets busy bit; committed write (we_o loaded 1) clears bit of its rd. Set and clear of the same bit in one cycle: set wins.
- issue_valid_i to a bit already set (and not being cleared that cycle) sets illegal_issue_o until reset.
- x0 never marked busy and never written.

## Timing
- Reset values: we_o 0, waddr_o 0, wdata_o 0, busy_o 0, illegal_issue_o 0, FIFO empty; alu_ready_o and mdu_ready_o 1.
- we_o/waddr_o/wdata_o registered; we_o high exactly one cycle per write, held stable across the register file's negedge write.
- ALU accepted at posedge N -> we_o high in cycle N+1; register file updated at negedge of N+1.
- MDU accepted at N (FIFO empty, no ALU traffic) -> popped at N+1 -> we_o in N+2.
- busy bit cleared at the same posedge that raises we_o; decode sees it clear in that cycle and reads the new value after the negedge write.
- Issue at posedge N -> busy bit visible from cycle N+1.
- Reset asserted mid-operation: FIFO flushed, outputs to reset values immediately; in-flight results discarded.

## Structure
- Shared package rv32_pkg: XLEN = 32, REG_ADDR_W = 5, NUM_REGS = 32, wb_entry struct {rd, data}.
- One sub-module: wb_fifo (parameterised synchronous FIFO, push/pop/full/empty/count, async active-high reset).
- Arbiter, output register and scoreboard in the top level.

## Test plan
- ALU only: alu rd=5 data=0x1234_5678 at N -> we_o=1, waddr_o=5, wdata_o=0x12345678 in N+1 only; busy_o[5] 1->0 if issued earlier.
- Collision: ALU rd=3 and MDU rd=7 valid same cycle -> x3 written N+1, x7 written N+2.
- Back-pressure: MDU pushes 4 results while ALU streams continuously -> mdu_ready_o low after 4th, next cycle FIFO head written, alu_ready_o low that cycle; all 4 MDU writes appear in push order.
- x0: ALU and MDU results with rd=0 -> handshakes complete, we_o stays 0, busy_o[0] stays 0.
- Scoreboard: issue rd=9, then second issue rd=9 before writeback -> illegal_issue_o=1 sticky; issue rd=9 in the same cycle as its commit -> busy_o[9] stays 1, no error.
- Reset with 3 FIFO entries and busy_o=0x0000_0880 -> all outputs reset values next sample, no further writes.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: register-file geometry and the write-back entry shared by the write-side logic
package rv32_pkg;
   localparam int XLEN = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS = 32;
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry;
   function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_ADDR_W-1:0] r);
      reg_bit = '0;
      reg_bit[r] = 1'b1;
   endfunction
endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// rf_writeback_arbiter_if: ALU/MDU result handshakes, issue port and register-file write port
interface rf_writeback_arbiter_if
   import rv32_pkg::*;
   ;
   logic                  alu_valid_i;
   logic [REG_ADDR_W-1:0] alu_rd_i;
   logic [XLEN-1:0]       alu_data_i;
   logic                  alu_ready_o;
   logic                  mdu_valid_i;
   logic [REG_ADDR_W-1:0] mdu_rd_i;
   logic [XLEN-1:0]       mdu_data_i;
   logic                  mdu_ready_o;
   logic                  issue_valid_i;
   logic [REG_ADDR_W-1:0] issue_rd_i;
   logic                  we_o;
   logic [REG_ADDR_W-1:0] waddr_o;
   logic [XLEN-1:0]       wdata_o;
   logic [NUM_REGS-1:0]   busy_o;
   logic                  illegal_issue_o;
   modport master (
      input  alu_valid_i, alu_rd_i, alu_data_i, mdu_valid_i, mdu_rd_i, mdu_data_i,
             issue_valid_i, issue_rd_i,
      output alu_ready_o, mdu_ready_o, we_o, waddr_o, wdata_o, busy_o, illegal_issue_o
   );
   modport slave (
      output alu_valid_i, alu_rd_i, alu_data_i, mdu_valid_i, mdu_rd_i, mdu_data_i,
             issue_valid_i, issue_rd_i,
      input  alu_ready_o, mdu_ready_o, we_o, waddr_o, wdata_o, busy_o, illegal_issue_o
   );
endinterface

// File: rtl/rf_writeback_arbiter_fifo.sv
// wb_fifo: synchronous FIFO buffering MDU results until the write port is free
module wb_fifo
   import rv32_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  wb_entry                    din,
   output wb_entry                    dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   wb_entry         mem_q [DEPTH];
   wb_entry         mem_d [DEPTH];
   logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]     cnt_q, cnt_d;
   // next-state: write at the tail, advance pointers, track occupancy
   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_q] = din;
      wr_d = push ? wr_q + AW'(1) : wr_q;
      rd_d = pop ? rd_q + AW'(1) : rd_q;
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
   end
   // storage and pointers; reset flushes everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   assign dout  = mem_q[rd_q];
   assign full  = cnt_q == (AW+1)'(DEPTH);
   assign empty = cnt_q == '0;
   assign count = cnt_q;
endmodule

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: merges ALU and buffered MDU results onto the register-file write port and tracks pending writes
module rf_writeback_arbiter
   import rv32_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input logic                    clk,
   input logic                    rst,
   rf_writeback_arbiter_if.master bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   wb_entry               head, push_ent;
   logic                  fifo_full, fifo_empty, push, pop, alu_wr;
   logic [CW-1:0]         fifo_cnt;
   logic                  we_q, we_d, ill_q, ill_d;
   logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
   logic [XLEN-1:0]       wdata_q, wdata_d;
   logic [NUM_REGS-1:0]   busy_q, busy_d, set_v, clr_v;
   assign push_ent = '{rd: bus.mdu_rd_i, data: bus.mdu_data_i};
   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (push_ent),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_cnt)
   );
   // fixed-priority arbitration: a full FIFO drains first, then ALU, then leftover FIFO entries
   always_comb begin
      bus.alu_ready_o = ~fifo_full;
      bus.mdu_ready_o = ~fifo_full;
      push = bus.mdu_valid_i & ~fifo_full & (bus.mdu_rd_i != '0);
      pop = (fifo_cnt == CW'(FIFO_DEPTH)) | (~bus.alu_valid_i & ~fifo_empty);
      alu_wr = ~fifo_full & bus.alu_valid_i & (bus.alu_rd_i != '0);
      we_d = pop | alu_wr;
      waddr_d = pop ? head.rd : alu_wr ? bus.alu_rd_i : waddr_q;
      wdata_d = pop ? head.data : alu_wr ? bus.alu_data_i : wdata_q;
      set_v = (bus.issue_valid_i && bus.issue_rd_i != '0) ? reg_bit(bus.issue_rd_i) : '0;
      clr_v = we_d ? reg_bit(waddr_d) : '0;
      busy_d = (busy_q & ~clr_v) | set_v;
      ill_d = ill_q | (|(set_v & busy_q & ~clr_v));
   end
   // registered write port and scoreboard; a commit clears its bit on the edge that raises we_o
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         busy_q  <= '0;
         ill_q   <= 1'b0;
      end else begin
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         ill_q   <= ill_d;
      end
   end
   assign bus.we_o            = we_q;
   assign bus.waddr_o         = waddr_q;
   assign bus.wdata_o         = wdata_q;
   assign bus.busy_o          = busy_q;
   assign bus.illegal_issue_o = ill_q;
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter: directed and random stimulus against a queue-based write-back model
module tb_rf_writeback_arbiter;
   localparam int DEPTH = 4;
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] d;
   } ent_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int errors = 0;
   int checks = 0;
   ent_t q[$];
   logic exp_we = 1'b0;
   logic [4:0] exp_wa = '0;
   logic [31:0] exp_wd = '0;
   logic [31:0] exp_busy = '0;
   logic exp_ill = 1'b0;
   bit acc_a, acc_m;
   rf_writeback_arbiter_if bus ();
   rf_writeback_arbiter #(.FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic idle();
      bus.alu_valid_i = 1'b0;
      bus.alu_rd_i = '0;
      bus.alu_data_i = '0;
      bus.mdu_valid_i = 1'b0;
      bus.mdu_rd_i = '0;
      bus.mdu_data_i = '0;
      bus.issue_valid_i = 1'b0;
      bus.issue_rd_i = '0;
   endtask
   task automatic model_reset();
      q.delete();
      exp_we = 1'b0;
      exp_wa = '0;
      exp_wd = '0;
      exp_busy = '0;
      exp_ill = 1'b0;
   endtask
   task automatic check_reset(input string tag);
      chk({tag, "_we"}, 32'(bus.we_o), 32'd0);
      chk({tag, "_waddr"}, 32'(bus.waddr_o), 32'd0);
      chk({tag, "_wdata"}, bus.wdata_o, 32'd0);
      chk({tag, "_busy"}, bus.busy_o, 32'd0);
      chk({tag, "_illegal"}, 32'(bus.illegal_issue_o), 32'd0);
      chk({tag, "_alu_ready"}, 32'(bus.alu_ready_o), 32'd1);
      chk({tag, "_mdu_ready"}, 32'(bus.mdu_ready_o), 32'd1);
   endtask
   // one clock: predict from the current inputs, clock, then compare
   task automatic cycle();
      bit full, wr;
      ent_t e;
      full = (q.size() == DEPTH);
      chk("alu_ready", 32'(bus.alu_ready_o), 32'(!full));
      chk("mdu_ready", 32'(bus.mdu_ready_o), 32'(!full));
      acc_a = bus.alu_valid_i && !full;
      acc_m = bus.mdu_valid_i && !full;
      wr = 1'b0;
      if (full) begin
         e = q.pop_front();
         wr = 1'b1;
      end else if (bus.alu_valid_i) begin
         if (bus.alu_rd_i != 0) begin
            wr = 1'b1;
            e = '{rd: bus.alu_rd_i, d: bus.alu_data_i};
         end
      end else if (q.size() != 0) begin
         e = q.pop_front();
         wr = 1'b1;
      end
      if (acc_m && bus.mdu_rd_i != 0) q.push_back('{rd: bus.mdu_rd_i, d: bus.mdu_data_i});
      exp_we = wr;
      if (wr) begin
         exp_wa = e.rd;
         exp_wd = e.d;
         exp_busy[e.rd] = 1'b0;
      end
      if (bus.issue_valid_i && bus.issue_rd_i != 0) begin
         if (exp_busy[bus.issue_rd_i]) exp_ill = 1'b1;
         exp_busy[bus.issue_rd_i] = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("we", 32'(bus.we_o), 32'(exp_we));
      if (exp_we) begin
         chk("waddr", 32'(bus.waddr_o), 32'(exp_wa));
         chk("wdata", bus.wdata_o, exp_wd);
      end
      chk("busy", bus.busy_o, exp_busy);
      chk("illegal", 32'(bus.illegal_issue_o), 32'(exp_ill));
   endtask
   task automatic alu(input logic [4:0] rd, input logic [31:0] d);
      bus.alu_valid_i = 1'b1;
      bus.alu_rd_i = rd;
      bus.alu_data_i = d;
   endtask
   task automatic mdu(input logic [4:0] rd, input logic [31:0] d);
      bus.mdu_valid_i = 1'b1;
      bus.mdu_rd_i = rd;
      bus.mdu_data_i = d;
   endtask
   task automatic issue(input logic [4:0] rd);
      bus.issue_valid_i = 1'b1;
      bus.issue_rd_i = rd;
   endtask
   initial begin
      idle();
      repeat (2) @(posedge clk);
      #1;
      check_reset("reset");
      rst = 1'b0;
      model_reset();
      // ALU only
      issue(5'd5);
      cycle();
      idle();
      alu(5'd5, 32'h1234_5678);
      cycle();
      chk("alu_we", 32'(bus.we_o), 32'd1);
      chk("alu_waddr", 32'(bus.waddr_o), 32'd5);
      chk("alu_wdata", bus.wdata_o, 32'h1234_5678);
      chk("alu_busy5", 32'(bus.busy_o[5]), 32'd0);
      idle();
      cycle();
      chk("alu_we_single", 32'(bus.we_o), 32'd0);
      // collision
      alu(5'd3, 32'hAAAA_0003);
      mdu(5'd7, 32'hBBBB_0007);
      cycle();
      chk("col_x3", 32'(bus.waddr_o), 32'd3);
      idle();
      cycle();
      chk("col_x7", 32'(bus.waddr_o), 32'd7);
      cycle();
      // back-pressure
      for (int k = 0; k < 4; k++) begin
         alu(5'(10 + k), 32'h100 + 32'(k));
         mdu(5'(20 + k), 32'h200 + 32'(k));
         cycle();
      end
      chk("bp_mdu_ready", 32'(bus.mdu_ready_o), 32'd0);
      chk("bp_alu_ready", 32'(bus.alu_ready_o), 32'd0);
      bus.mdu_valid_i = 1'b0;
      alu(5'd14, 32'h104);
      cycle();
      chk("bp_head", 32'(bus.waddr_o), 32'd20);
      cycle();
      chk("bp_alu_after", 32'(bus.waddr_o), 32'd14);
      idle();
      repeat (4) cycle();
      // x0
      alu(5'd0, 32'hDEAD_0000);
      mdu(5'd0, 32'hBEEF_0000);
      issue(5'd0);
      cycle();
      idle();
      repeat (2) cycle();
      chk("x0_busy0", 32'(bus.busy_o[0]), 32'd0);
      // scoreboard: issue coinciding with its own commit
      issue(5'd9);
      cycle();
      alu(5'd9, 32'h0000_0009);
      cycle();
      chk("sb_same_busy", 32'(bus.busy_o[9]), 32'd1);
      chk("sb_same_ill", 32'(bus.illegal_issue_o), 32'd0);
      idle();
      alu(5'd9, 32'h0000_0099);
      cycle();
      idle();
      issue(5'd9);
      cycle();
      cycle();
      chk("sb_double_ill", 32'(bus.illegal_issue_o), 32'd1);
      idle();
      repeat (2) cycle();
      chk("sb_sticky", 32'(bus.illegal_issue_o), 32'd1);
      // reset mid-operation
      alu(5'd9, 32'h9);
      cycle();
      idle();
      issue(5'd7);
      cycle();
      issue(5'd11);
      cycle();
      idle();
      for (int k = 0; k < 3; k++) begin
         alu(5'(1 + k), 32'h300 + 32'(k));
         mdu(5'(4 + k), 32'h400 + 32'(k));
         cycle();
      end
      chk("pre_rst_busy", bus.busy_o, 32'h0000_0880);
      idle();
      #2 rst = 1'b1;
      #1 check_reset("async_rst");
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) cycle();
      // random traffic
      acc_a = 1'b0;
      acc_m = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (acc_a || !bus.alu_valid_i) begin
            bus.alu_valid_i = $urandom_range(0, 3) != 0;
            bus.alu_rd_i = 5'($urandom_range(0, 31));
            bus.alu_data_i = $urandom;
         end
         if (acc_m || !bus.mdu_valid_i) begin
            bus.mdu_valid_i = $urandom_range(0, 1) != 0;
            bus.mdu_rd_i = 5'($urandom_range(0, 31));
            bus.mdu_data_i = $urandom;
         end
         bus.issue_valid_i = $urandom_range(0, 3) == 0;
         bus.issue_rd_i = 5'($urandom_range(0, 31));
         cycle();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
